// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell, one bit per clock, LSB first.
// Operands are captured on accept; the result is held in DONE until the consumer takes it.
module serial_add_ctrl #(
    parameter int WIDTH = 11,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready depends only on state; in_valid is neither queued nor remembered while busy.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               carry;
    logic [CNT_W-1:0]   idx;
    logic               bit_a;
    logic               bit_b;
    logic               s;
    logic               c;
    logic               last_bit;

    assign bit_a    = opa[idx];
    assign bit_b    = opb[idx];
    assign s        = bit_a ^ bit_b ^ carry;
    assign c        = (bit_a & bit_b) | (carry & (bit_a | bit_b));
    assign last_bit = (idx == CNT_W'(WIDTH - 1));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        sum   <= '0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum[idx] <= s;
                    carry    <= c;
                    // The final carry is the only path to cout; sum wraps modulo 2^WIDTH.
                    if (last_bit) begin
                        cout <= c;
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus a randomized sweep,
// with expected {cout,sum} values queued at stimulus time and popped at the result handshake.
module tb_serial_add_ctrl;

    localparam int WIDTH = 11;
    localparam int W     = WIDTH + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_errors;
    int           cyc;
    int           acc_cyc;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic ci);
        return W'(x) + W'(y) + W'(ci);
    endfunction

    // A valid result must always correspond to an accepted, not-yet-consumed request.
    always @(negedge clk) begin
        if (out_valid) check("ov_without_accept", W'(exp_q.size() != 0), W'(1));
    end

    // Drives a request at a negedge, returns at the negedge after the accept edge.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
        int n;
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
        exp_q.push_back(model(x, y, ci));
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", W'(in_ready), W'(1));
        @(posedge clk);
        acc_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
    endtask

    // Waits for the result, stalls, compares, then completes the handshake.
    task automatic receive(input int stall);
        int n;
        logic [W-1:0] exp;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check("result_timeout", W'(out_valid), W'(1));
            return;
        end
        check("latency", W'(cyc - acc_cyc), W'(WIDTH));
        exp = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("result", {cout, sum}, exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", W'(out_valid), W'(1));
            check("hold_result", {cout, sum}, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check("idle_in_ready", W'(in_ready), W'(1));
        check("idle_out_valid", W'(out_valid), W'(0));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        acc_cyc   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_result", {cout, sum}, W'(0));

        // Full carry ripple
        send(11'h7FF, 11'h001, 1'b0);
        check("run_busy", W'(busy), W'(1));
        check("run_in_ready", W'(in_ready), W'(0));
        receive(0);
        check("ripple_const", model(11'h7FF, 11'h001, 1'b0), 12'h800);

        // Carry-in path
        send(11'h4D2, 11'h237, 1'b1);
        receive(1);

        // Backpressure
        send(11'h400, 11'h400, 1'b0);
        receive(5);

        // Busy rejection and mid-run operand changes
        send(11'h155, 11'h2AA, 1'b1);
        in_valid = 1'b1;
        a        = 11'h111;
        b        = 11'h222;
        cin      = 1'b0;
        exp_q.push_back(model(11'h111, 11'h222, 1'b0));
        for (int i = 0; i < 4; i++) begin
            check("busy_reject", W'(in_ready), W'(0));
            a = ~a;
            b = b ^ 11'h5A5;
            @(negedge clk);
        end
        a = 11'h111;
        b = 11'h222;
        receive(2);
        @(posedge clk);
        acc_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        receive(0);

        // Reset mid-operation at idx=5
        send(11'h3FF, 11'h0F0, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", W'(in_ready), W'(1));
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_busy", W'(busy), W'(0));
        check("abort_result", {cout, sum}, W'(0));
        send(11'h003, 11'h005, 1'b0);
        receive(0);

        // Randomized sweep
        for (int t = 0; t < 200; t++) begin
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            receive($urandom_range(0, 3));
        end

        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
